// File: rtl/icache_axi_pkg.sv
// Shared types and AXI constants for the instruction-cache AXI read stage.
package icache_axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Top address bits selecting the kseg0/kseg1 unmapped windows.
   localparam logic [1:0] KSEG01_SEL     = 2'b10;

endpackage

// File: rtl/icache_addr_map.sv
// Miss-address to bus-address map; ICACHE_KSEG_MAP_EN folds kseg0/kseg1 onto
// physical low memory, otherwise the address passes through unchanged.
module icache_addr_map
   import icache_axi_pkg::*;
#(
   parameter int unsigned A_WIDTH = 32
) (
   input  logic [A_WIDTH-1:0] a,
   output logic [A_WIDTH-1:0] mapped
);

`ifdef ICACHE_KSEG_MAP_EN
   // kseg0/kseg1 share the same physical window: clear the segment bits.
   always_comb begin
      mapped = a;
      if (a[31:30] == KSEG01_SEL) begin
         mapped[31:29] = 3'b000;
      end
   end
`else
   assign mapped = a;
`endif

endmodule

// File: rtl/icache_axi_rd.sv
// Single-beat AXI4 read engine serving instruction-cache misses.
// Optional address map enabled by ICACHE_KSEG_MAP_EN (see icache_addr_map).
module icache_axi_rd
   import icache_axi_pkg::*;
#(
   parameter int unsigned A_WIDTH  = 32,
   parameter int unsigned ID_WIDTH = 4,
   parameter int unsigned AXI_ID   = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [A_WIDTH-1:0]  m_a,
   input  logic                m_strobe,
   output logic [31:0]         m_dout,
   output logic                m_ready,
   output logic [ID_WIDTH-1:0] arid,
   output logic [A_WIDTH-1:0]  araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic                arvalid,
   input  logic                arready,
   input  logic [31:0]         rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,
   output logic                rd_err
);

   state_t             state;
   logic [A_WIDTH-1:0] mapped_a;

   icache_addr_map #(.A_WIDTH(A_WIDTH)) u_addr_map (
      .a      (m_a),
      .mapped (mapped_a)
   );

   assign arid    = ID_WIDTH'(AXI_ID);
   assign arlen   = 8'd0;
   assign arsize  = AXI_SIZE_4B;
   assign arburst = AXI_BURST_INCR;

   // Request FSM with registered AXI handshake and cache-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         m_ready <= 1'b0;
         m_dout  <= 32'd0;
         araddr  <= '0;
         rd_err  <= 1'b0;
      end else begin
         m_ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (m_strobe) begin
                  araddr  <= mapped_a;
                  arvalid <= 1'b1;
                  state   <= ST_AR;
               end
            end
            ST_AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= ST_R;
               end
            end
            ST_R: begin
               if (rvalid && rready) begin
                  m_dout  <= rdata;
                  rready  <= 1'b0;
                  m_ready <= 1'b1;
                  state   <= ST_RESP;
                  // A bad response still returns data; the flag is sticky.
                  if (rresp != AXI_RESP_OKAY || !rlast) begin
                     rd_err <= 1'b1;
                  end
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_axi_rd.sv
// Scoreboard bench for icache_axi_rd; map expectations follow ICACHE_KSEG_MAP_EN.
module tb_icache_axi_rd;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m_a;
   logic        m_strobe;
   logic [31:0] m_dout;
   logic        m_ready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        rd_err;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic exp_err = 1'b0;
   exp_t sb_q[$];
   exp_t mon_e;

   icache_axi_rd #(.A_WIDTH(32), .ID_WIDTH(4), .AXI_ID(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .m_a      (m_a),
      .m_strobe (m_strobe),
      .m_dout   (m_dout),
      .m_ready  (m_ready),
      .arid     (arid),
      .araddr   (araddr),
      .arlen    (arlen),
      .arsize   (arsize),
      .arburst  (arburst),
      .arvalid  (arvalid),
      .arready  (arready),
      .rdata    (rdata),
      .rresp    (rresp),
      .rlast    (rlast),
      .rvalid   (rvalid),
      .rready   (rready),
      .rd_err   (rd_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Every m_ready pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      if (!rst && m_ready) begin
         if (sb_q.size() == 0) begin
            check("m_ready_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("m_dout", m_dout, mon_e.data);
            check("rd_err", 32'(rd_err), 32'(mon_e.err));
         end
      end
   end

   task automatic txn(input logic [31:0] addr, input logic [31:0] exp_addr,
                      input logic [31:0] data, input logic [1:0] resp, input logic last,
                      input int ar_wait, input int r_wait, input bit flush);
      int t0;
      bit ok;
      exp_t e;
      exp_err = exp_err | (resp != 2'b00) | !last;
      e.data = data;
      e.err  = exp_err;
      sb_q.push_back(e);
      m_a = addr;
      m_strobe = 1'b1;
      t0 = cyc;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = arvalid;
      end
      check("arvalid_rise", 32'(ok), 32'd1);
      if (!ok) begin
         m_strobe = 1'b0;
         void'(sb_q.pop_back());
         return;
      end
      check("ar_latency", 32'(cyc - t0), 32'd1);
      check("araddr", araddr, exp_addr);
      for (int i = 0; i < ar_wait; i++) begin
         if (flush) m_a = ~addr;
         @(negedge clk);
         check("arvalid_hold", 32'(arvalid), 32'd1);
         check("araddr_hold", araddr, exp_addr);
         check("rready_in_ar", 32'(rready), 32'd0);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      check("arvalid_drop", 32'(arvalid), 32'd0);
      check("rready_in_r", 32'(rready), 32'd1);
      for (int i = 0; i < r_wait; i++) begin
         if (flush) m_strobe = 1'b0;
         @(negedge clk);
         check("rready_wait", 32'(rready), 32'd1);
         check("m_ready_early", 32'(m_ready), 32'd0);
         check("araddr_r", araddr, exp_addr);
      end
      if (flush) m_strobe = 1'b0;
      rdata  = data;
      rresp  = resp;
      rlast  = last;
      rvalid = 1'b1;
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = 32'h0;
      rresp  = 2'b00;
      rlast  = 1'b1;
      check("m_ready", 32'(m_ready), 32'd1);
      check("rsp_latency", 32'(cyc - t0), 32'(3 + ar_wait + r_wait));
      check("rready_after", 32'(rready), 32'd0);
      m_strobe = 1'b0;
      @(negedge clk);
      check("m_ready_pulse", 32'(m_ready), 32'd0);
      check("arvalid_idle", 32'(arvalid), 32'd0);
   endtask

   logic [31:0] map_exp0, map_exp1;

   initial begin
      rst = 1'b1; m_a = 32'h0; m_strobe = 1'b0; arready = 1'b0;
      rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_rready", 32'(rready), 32'd0);
      check("rst_m_ready", 32'(m_ready), 32'd0);
      check("rst_m_dout", m_dout, 32'd0);
      check("rst_araddr", araddr, 32'd0);
      check("rst_rd_err", 32'(rd_err), 32'd0);
      check("const_ar", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b010, 2'b01});

      txn(32'h0000_1000, 32'h0000_1000, 32'h2408_0001, 2'b00, 1'b1, 0, 0, 1'b0);
      txn(32'h0000_2004, 32'h0000_2004, 32'h1234_5678, 2'b00, 1'b1, 5, 4, 1'b0);
      txn(32'h0000_3000, 32'h0000_3000, 32'hDEAD_BEEF, 2'b10, 1'b1, 0, 0, 1'b0);
      txn(32'h0000_3004, 32'h0000_3004, 32'hCAFE_0001, 2'b00, 1'b1, 1, 1, 1'b0);
      txn(32'h0000_3008, 32'h0000_3008, 32'h5555_AAAA, 2'b00, 1'b1, 2, 0, 1'b0);
      txn(32'h0000_4000, 32'h0000_4000, 32'h0BAD_F00D, 2'b00, 1'b1, 3, 2, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("no_ar_after_flush", 32'(arvalid), 32'd0);
      end

      // Reset while the AR handshake is pending.
      m_a = 32'h0000_5000;
      m_strobe = 1'b1;
      @(negedge clk);
      check("ar_before_rst", 32'(arvalid), 32'd1);
      rst = 1'b1;
      m_strobe = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_err = 1'b0;
      check("rst_ar_arvalid", 32'(arvalid), 32'd0);
      check("rst_ar_rready", 32'(rready), 32'd0);
      check("rst_ar_m_ready", 32'(m_ready), 32'd0);
      check("rst_ar_rd_err", 32'(rd_err), 32'd0);
      @(negedge clk);
      check("rst_ar_idle", 32'(arvalid), 32'd0);
      txn(32'h0000_6000, 32'h0000_6000, 32'h7777_0001, 2'b00, 1'b1, 0, 0, 1'b0);
      txn(32'h0000_6004, 32'h0000_6004, 32'h7777_0002, 2'b00, 1'b0, 0, 1, 1'b0);

`ifdef ICACHE_KSEG_MAP_EN
      map_exp0 = 32'h1FC0_0000;
      map_exp1 = 32'h0000_0100;
`else
      map_exp0 = 32'hBFC0_0000;
      map_exp1 = 32'h8000_0100;
`endif
      txn(32'hBFC0_0000, map_exp0, 32'h3C1C_0000, 2'b00, 1'b1, 0, 0, 1'b0);
      txn(32'h8000_0100, map_exp1, 32'h2000_0001, 2'b00, 1'b1, 1, 0, 1'b0);
      txn(32'h4000_0010, 32'h4000_0010, 32'h0000_0010, 2'b00, 1'b1, 0, 0, 1'b0);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
